// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: shared types and constants for the exception sequencer
package exc_ctrl_pkg;
  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;
  localparam int W_INTV = 8;
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;
  localparam int F_ADEL_I = 0;
  localparam int F_RI     = 1;
  localparam int F_SYS    = 2;
  localparam int F_BP     = 3;
  localparam int F_OV     = 4;
  localparam int F_ADE_D  = 5;
  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} exc_state_t;
  typedef enum logic [1:0] {BVA_KEEP, BVA_PC, BVA_ADDR} bva_sel_t;
  typedef struct packed {
    logic        we;
    logic        bd;
    logic        exl;
    logic [4:0]  exc;
    logic [31:0] epc;
    logic [31:0] bva;
  } reg_error;
endpackage

// File: rtl/exc_ctrl_prio.sv
// exc_prio: priority encoder from interrupt/exception flags/ERET to the selected event
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic [W_INTV-1:0] intr_vect,
  input  logic [5:0]        exc_flags,
  input  logic              is_store,
  input  logic              eret,
  output logic              hit,
  output logic [4:0]        code,
  output logic              is_eret,
  output bva_sel_t          bva_sel
);
  logic intr;
  logic any_exc;
  // interrupt beats every flag, flags beat ERET, bit0 is the highest flag
  always_comb begin
    intr    = |intr_vect;
    any_exc = |exc_flags;
    hit     = intr | any_exc | eret;
    is_eret = eret & ~intr & ~any_exc;
    code    = intr                ? EXC_INT :
              exc_flags[F_ADEL_I] ? EXC_ADEL :
              exc_flags[F_RI]     ? EXC_RI :
              exc_flags[F_SYS]    ? EXC_SYS :
              exc_flags[F_BP]     ? EXC_BP :
              exc_flags[F_OV]     ? EXC_OV :
              exc_flags[F_ADE_D]  ? (is_store ? EXC_ADES : EXC_ADEL) : 5'h00;
    bva_sel = intr                     ? BVA_KEEP :
              exc_flags[F_ADEL_I]      ? BVA_PC :
              (|exc_flags[F_OV:F_RI])  ? BVA_KEEP :
              exc_flags[F_ADE_D]       ? BVA_ADDR : BVA_KEEP;
  end
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: commit-point exception/interrupt sequencer with flush, drain and redirect
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = 32'hBFC00380
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  input  logic [W_ADDR-1:0] commit_pc,
  input  logic [W_ADDR-1:0] commit_addr,
  input  logic              commit_bd,
  input  logic [5:0]        commit_exc,
  input  logic              commit_store,
  input  logic              commit_eret,
  input  logic [W_INTV-1:0] intr_vect,
  input  logic [W_ADDR-1:0] er_epc,
  input  logic [W_DATA-1:0] cause_q,
  input  logic [W_DATA-1:0] badv_q,
  input  logic              mem_busy,
  output reg_error          cp0w,
  output logic              flush,
  output logic              redirect_valid,
  output logic [W_ADDR-1:0] redirect_pc,
  output logic              busy
);
  exc_state_t        state_q, state_d;
  logic [W_ADDR-1:0] tgt_q, tgt_d;
  logic              hit, is_eret, ev;
  logic [4:0]        code;
  bva_sel_t          bva_sel;

  exc_prio u_prio (
    .intr_vect (intr_vect),
    .exc_flags (commit_exc),
    .is_store  (commit_store),
    .eret      (commit_eret),
    .hit       (hit),
    .code      (code),
    .is_eret   (is_eret),
    .bva_sel   (bva_sel)
  );

  // state and redirect target registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  // next state, latched target and all outputs; the event is only taken in IDLE
  always_comb begin
    ev             = (state_q == IDLE) && commit_valid && hit && !rst;
    state_d        = state_q;
    tgt_d          = ev ? (is_eret ? er_epc : EXC_VEC) : tgt_q;
    cp0w           = '0;
    busy           = state_q != IDLE;
    flush          = ev | busy;
    redirect_valid = state_q == REDIRECT;
    redirect_pc    = redirect_valid ? tgt_q : '0;
    case (state_q)
      IDLE:     state_d = ev ? (mem_busy ? DRAIN : REDIRECT) : IDLE;
      DRAIN:    state_d = mem_busy ? DRAIN : REDIRECT;
      default:  state_d = IDLE;
    endcase
    if (ev) begin
      cp0w.we  = 1'b1;
      cp0w.bd  = is_eret ? cause_q[31] : commit_bd;
      cp0w.exl = !is_eret;
      cp0w.exc = is_eret ? cause_q[6:2] : code;
      cp0w.epc = is_eret ? er_epc : (commit_bd ? commit_pc - 32'd4 : commit_pc);
      cp0w.bva = bva_sel == BVA_PC ? commit_pc : bva_sel == BVA_ADDR ? commit_addr : badv_q;
    end
  end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: randomized scoreboard bench for exc_ctrl
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;
  logic        clk = 0, rst = 1;
  logic        commit_valid = 0, commit_bd = 0, commit_store = 0, commit_eret = 0, mem_busy = 0;
  logic [31:0] commit_pc = 0, commit_addr = 0, er_epc = 0, cause_q = 0, badv_q = 0;
  logic [5:0]  commit_exc = 0;
  logic [7:0]  intr_vect = 0;
  reg_error    cp0w;
  logic        flush, redirect_valid, busy;
  logic [31:0] redirect_pc;
  int          vectors = 0, miscompares = 0, cyc = 0;
  reg_error    exp_w[$];
  logic [31:0] exp_pc[$];
  int          exp_cyc[$];
  logic        mon_en = 0;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_addr(commit_addr), .commit_bd(commit_bd), .commit_exc(commit_exc),
    .commit_store(commit_store), .commit_eret(commit_eret), .intr_vect(intr_vect),
    .er_epc(er_epc), .cause_q(cause_q), .badv_q(badv_q), .mem_busy(mem_busy),
    .cp0w(cp0w), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT shows a cp0 write or a redirect
  always @(negedge clk) if (mon_en && !rst) begin
    if (cp0w.we) begin
      if (exp_w.size() == 0) chk("unexpected_cp0w", {23'h0, cp0w}, '0);
      else chk("cp0w", {23'h0, cp0w}, {23'h0, exp_w.pop_front()});
    end
    if (redirect_valid) begin
      if (exp_pc.size() == 0) chk("unexpected_redirect", {64'h0, redirect_pc}, '0);
      else begin
        chk("redirect_pc", {64'h0, redirect_pc}, {64'h0, exp_pc.pop_front()});
        chk("redirect_cycle", 96'(cyc), 96'(exp_cyc.pop_front()));
      end
    end else chk("redirect_pc_idle", {64'h0, redirect_pc}, '0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // inputs that must never create an event: either no commit, or a clean commit
  task automatic idle_inputs();
    commit_valid = 1'($urandom);
    commit_pc    = $urandom;
    commit_addr  = $urandom;
    commit_bd    = 1'($urandom);
    commit_store = 1'($urandom);
    mem_busy     = 1'($urandom);
    if (commit_valid) begin
      commit_exc = 0;
      commit_eret = 0;
      intr_vect = 0;
    end else begin
      commit_exc = 6'($urandom);
      commit_eret = 1'($urandom);
      intr_vect = 8'($urandom);
    end
  endtask

  // anything at all; the DUT is mid-sequence and must ignore it
  task automatic junk_inputs();
    commit_valid = 1'($urandom);
    commit_pc    = $urandom;
    commit_addr  = $urandom;
    commit_bd    = 1'($urandom);
    commit_store = 1'($urandom);
    commit_exc   = 6'($urandom);
    commit_eret  = 1'($urandom);
    intr_vect    = 8'($urandom);
    er_epc       = $urandom;
    cause_q      = $urandom;
    badv_q       = $urandom;
  endtask

  // reference model: MIPS priority rules written out directly
  function automatic reg_error model(input logic [31:0] pc, addr, input logic bd,
      input logic [5:0] ex, input logic st, input logic [7:0] iv,
      input logic [31:0] epc_in, cause, badv, output logic [31:0] tgt);
    reg_error e;
    e.we  = 1;
    e.bd  = bd;
    e.exl = 1;
    e.epc = bd ? pc - 4 : pc;
    e.bva = badv;
    tgt   = 32'hBFC00380;
    if (iv != 0) e.exc = 5'h00;
    else if (ex[0]) begin e.exc = 5'h04; e.bva = pc; end
    else if (ex[1]) e.exc = 5'h0A;
    else if (ex[2]) e.exc = 5'h08;
    else if (ex[3]) e.exc = 5'h09;
    else if (ex[4]) e.exc = 5'h0C;
    else if (ex[5]) begin e.exc = st ? 5'h05 : 5'h04; e.bva = addr; end
    else begin
      e.bd  = cause[31];
      e.exl = 0;
      e.exc = cause[6:2];
      e.epc = epc_in;
      tgt   = epc_in;
    end
    return e;
  endfunction

  // one event at the commit stage, with n busy cycles before the redirect
  task automatic do_event(input logic [31:0] pc, addr, input logic bd, input logic [5:0] ex,
      input logic st, er, input logic [7:0] iv, input logic [31:0] epc_in, cause, badv, input int n);
    logic [31:0] tgt;
    exp_w.push_back(model(pc, addr, bd, ex, st, iv, epc_in, cause, badv, tgt));
    exp_pc.push_back(tgt);
    exp_cyc.push_back(cyc + 1 + n);
    commit_valid = 1; commit_pc = pc; commit_addr = addr; commit_bd = bd;
    commit_exc = ex; commit_store = st; commit_eret = er; intr_vect = iv;
    er_epc = epc_in; cause_q = cause; badv_q = badv; mem_busy = n > 0;
    #2 chk("flush_T", 96'(flush), 96'd1);
    for (int k = 1; k <= n + 1; k++) begin
      step();
      junk_inputs();
      mem_busy = k < n;
      #1 chk("flush_busy", {94'h0, flush, busy}, {94'h0, 2'b11});
    end
    step();
    commit_valid = 0;
    mem_busy = 0;
    #1 chk("back_idle", {94'h0, flush, busy}, '0);
  endtask

  initial begin
    #1;
    chk("reset_outputs", {22'h0, cp0w, flush, redirect_valid, busy}, '0);
    chk("reset_rpc", {64'h0, redirect_pc}, '0);
    step();
    step();
    rst = 0;
    mon_en = 1;
    step();
    do_event(32'h80001000, 0, 0, 6'b000100, 0, 0, 0, 0, 0, 32'h1234, 0);
    do_event(32'h80002004, 32'h3, 1, 6'b100000, 1, 0, 0, 0, 0, 32'h5555, 1);
    do_event(32'h80004000, 0, 0, 6'b000010, 0, 0, 8'h04, 0, 0, 32'hABCD0000, 0);
    do_event(32'h80005000, 0, 0, 0, 0, 1, 0, 32'h80003010, 32'h80000030, 32'h77, 3);
    do_event(32'h80006000, 0, 0, 6'b010000, 0, 0, 0, 0, 0, 0, 4);
    do_event(32'h80007000, 32'h8, 0, 6'b100001, 0, 1, 0, 32'h9, 0, 32'h1, 0);
    for (int i = 0; i < 60; i++) begin
      logic [5:0] ex;
      logic       er;
      logic [7:0] iv;
      ex = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'(1 << $urandom_range(0, 5)) | 6'($urandom & $urandom);
      er = 1'($urandom);
      iv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      if (ex == 0 && iv == 0) er = 1;
      do_event($urandom, $urandom, 1'($urandom), ex, 1'($urandom), er, iv,
               $urandom, $urandom, $urandom, $urandom_range(0, 4));
      for (int j = $urandom_range(0, 3); j > 0; j--) begin
        idle_inputs();
        step();
      end
      commit_valid = 0;
    end
    // reset in the middle of DRAIN: the sequence is abandoned
    begin
      logic [31:0] tgt;
      exp_w.push_back(model(32'h80008000, 0, 0, 6'b000100, 0, 0, 0, 0, 0, tgt));
      commit_valid = 1; commit_pc = 32'h80008000; commit_bd = 0; commit_exc = 6'b000100;
      commit_store = 0; commit_eret = 0; intr_vect = 0; badv_q = 0; mem_busy = 1;
      step();
      commit_valid = 0;
      step();
      #2 chk("drain_busy", {94'h0, flush, busy}, {94'h0, 2'b11});
      rst = 1;
      #1 chk("async_rst", {93'h0, flush, busy, redirect_valid}, '0);
      mem_busy = 0;
      step();
      rst = 0;
      for (int j = 0; j < 6; j++) step();
      chk("rst_no_redirect", {94'h0, flush, busy}, '0);
    end
    for (int j = 0; j < 4; j++) step();
    chk("queues_empty", 96'(exp_w.size() + exp_pc.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer at the commit point of the pipeline.
- Arbitrates pending instruction exceptions, pending interrupts and ERET, and drives the cp0 exception write record (cp0w).
- Flushes the pipeline, waits for outstanding memory transactions to drain, then issues a one-cycle PC redirect to the handler vector or to EPC.

Parameters:
- EXC_VEC, 32'hBFC00380, handler entry address for all exceptions and interrupts.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- commit_valid  in  1  a valid instruction occupies the commit stage this cycle
- commit_pc  in  `W_ADDR  PC of the committing instruction
- commit_addr  in  `W_ADDR  data address of a committing load/store
- commit_bd  in  1  committing instruction is in a branch delay slot
- commit_exc  in  6  exception flags, bit0 fetch AdEL, bit1 RI, bit2 Sys, bit3 Bp, bit4 Ov, bit5 data AdEL/AdES
- commit_store  in  1  committing instruction is a store (selects AdES vs AdEL)
- commit_eret  in  1  committing instruction is ERET
- intr_vect  in  `W_INTV  masked interrupt vector from cp0
- er_epc  in  `W_ADDR  current EPC from cp0
- cause_q  in  `W_DATA  current Cause register
- badv_q  in  `W_DATA  current BadVAddr register
- mem_busy  in  1  data/instruction bus has outstanding transactions
- cp0w  out  reg_error  exception write record to cp0 (we, bd, exl, exc, epc, bva)
- flush  out  1  kill all pipeline stages, including commit write-back
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  `W_ADDR  redirect target
- busy  out  1  state != IDLE

Behaviour:
- One clock; reset is asynchronous and active-high. On reset: state=IDLE, all outputs 0, latched target 0.
- States: IDLE, DRAIN, REDIRECT.
- Event in IDLE requires commit_valid=1. Priority, highest first:
  - interrupt (intr_vect != 0)
  - fetch AdEL
  - RI
  - Sys
  - Bp
  - Ov
  - data AdEL/AdES
  - ERET
  - Lower-priority flags are ignored once a higher one is selected.
- Exception codes (5-bit):
  - Int 0x00, AdEL 0x04, AdES 0x05, Sys 0x08, Bp 0x09, RI 0x0A, Ov 0x0C.
  - AdES is used only when bit5 is set and commit_store=1.
- Event cycle T (combinational, IDLE only):
  - flush=1 and cp0w.we=1 for exactly one cycle.
  - For an exception or interrupt: bd=commit_bd, exl=1, exc=code, epc = commit_bd ? commit_pc-4 : commit_pc (32-bit wrap).
  - bva: commit_pc for fetch AdEL; commit_addr for data AdEL/AdES; badv_q otherwise.
  - For ERET: exl=0; bd=cause_q[31], exc=cause_q[6:2], epc=er_epc, bva=badv_q, so cp0 fields are preserved.
  - Target is latched at the T edge: EXC_VEC for exceptions/interrupts, er_epc for ERET.
- Transitions:
  - IDLE→DRAIN if an event occurs and mem_busy=1.
  - IDLE→REDIRECT if an event occurs and mem_busy=0.
  - DRAIN→REDIRECT on the first cycle mem_busy=0 (DRAIN has no timeout).
  - REDIRECT→IDLE unconditionally.
- In DRAIN and REDIRECT: flush=1, cp0w.we=0, busy=1. All commit inputs and interrupts are ignored.
- In REDIRECT: redirect_valid=1, redirect_pc=latched target.
- Minimum latency: redirect at T+1. With n busy cycles after T, redirect at T+1+n.
- An interrupt arriving while not in IDLE is not lost: it is re-evaluated in the first IDLE cycle with commit_valid=1.
- Asynchronous reset in DRAIN or REDIRECT aborts the sequence; no redirect is issued afterwards.
- redirect_pc=0 whenever redirect_valid=0.

Decomposition:
- Shared package (includes):
  - exception code constants EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV
  - enum exc_state_t {IDLE, DRAIN, REDIRECT}
  - exc flag bit index constants
  - reuse the existing reg_error struct
- One natural sub-module, exc_prio: purely combinational priority encoder from the interrupt/flag/ERET inputs to {hit, code, is_eret, bva_sel}.

Test Plan:
- Sys at commit_pc=0x80001000, commit_bd=0, mem_busy=0 → cycle T: cp0w.we=1, exc=0x08, exl=1, epc=0x80001000; T+1: redirect_valid=1, redirect_pc=0xBFC00380; T+2: IDLE.
- Data AdES in a delay slot: commit_pc=0x80002004, commit_bd=1, commit_store=1, commit_addr=0x00000003 → exc=0x05, bd=1, epc=0x80002000, bva=0x00000003.
- intr_vect=0x04 together with commit_exc RI → exc=0x00 (interrupt wins), epc=commit_pc, bva=badv_q.
- ERET with er_epc=0x80003010, cause_q=0x80000030, mem_busy=1 for 3 cycles → T: we=1, exl=0, bd=1, exc=0x0C, epc=0x80003010; DRAIN for 3 cycles with flush=1; redirect_pc=0x80003010 at T+4.
- A second Ov at commit during DRAIN is ignored: no second cp0w.we pulse and exactly one redirect.
- rst asserted mid-DRAIN → flush, busy and redirect_valid fall immediately (asynchronously); no redirect follows after rst deasserts.
